// File: rtl/rv_imm_pkg.sv
// Shared RISC-V immediate-format definitions: format codes, per-format field masks
// and base opcodes used when building instruction words.
package rv_imm_pkg;

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } imm_fmt_e;

    localparam logic [31:0] MASK_I = 32'hFFF00000;
    localparam logic [31:0] MASK_S = 32'hFE000F80;
    localparam logic [31:0] MASK_B = 32'hFE000F80;
    localparam logic [31:0] MASK_J = 32'hFFFFF000;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    function automatic logic [31:0] fmt_mask(input imm_fmt_e fmt);
        logic [31:0] m;
        case (fmt)
            FMT_I:   m = MASK_I;
            FMT_S:   m = MASK_S;
            FMT_B:   m = MASK_B;
            default: m = MASK_J;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational scatter of a signed immediate into the RISC-V immediate bit
// positions of an instruction word, with a representability check.
module imm_scatter
    import rv_imm_pkg::*;
(
    input  logic [1:0]  in_src,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_base,
    output logic [31:0] instr,
    output logic        err
);

    imm_fmt_e    fmt;
    logic [31:0] fields;

    assign fmt = imm_fmt_e'(in_src);

    // Out-of-range immediates still produce truncated fields; err flags them.
    always_comb begin
        fields = '0;
        err    = 1'b0;
        case (fmt)
            FMT_I: begin
                fields = {in_imm[11:0], 20'b0};
                err    = (in_imm[31:11] != '0) && (in_imm[31:11] != '1);
            end
            FMT_S: begin
                fields = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
                err    = (in_imm[31:11] != '0) && (in_imm[31:11] != '1);
            end
            FMT_B: begin
                fields = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
                err    = ((in_imm[31:12] != '0) && (in_imm[31:12] != '1)) || in_imm[0];
            end
            default: begin
                fields = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
                err    = ((in_imm[31:20] != '0) && (in_imm[31:20] != '1)) || in_imm[0];
            end
        endcase
        instr = (in_base & ~fmt_mask(fmt)) | fields;
    end

endmodule

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: one output register stage with valid/ready on both
// sides, instruction-memory address counter and saturating error counter.
module imm_encoder
    import rv_imm_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_src,
    input  logic [31:0]         in_imm,
    input  logic [31:0]         in_base,
    input  logic                addr_load,
    input  logic [ADDR_W-1:0]   addr_start,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
    logic                out_err_q,   out_err_d;
    logic [ERRCNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic [ADDR_W-1:0]   next_addr_q, next_addr_d;

    logic [31:0]       enc_instr;
    logic              enc_err;
    logic              accept;
    logic [ADDR_W-1:0] addr_base;

    imm_scatter u_scatter (
        .in_src  (in_src),
        .in_imm  (in_imm),
        .in_base (in_base),
        .instr   (enc_instr),
        .err     (enc_err)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A same-cycle addr_load redirects the accepted beat itself.
    assign addr_base = addr_load ? addr_start : next_addr_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;
        next_addr_d = addr_base;
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr;
            out_addr_d  = addr_base;
            out_err_d   = enc_err;
            next_addr_d = addr_base + ADDR_W'(4);
            if (enc_err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + ERRCNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            next_addr_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
            next_addr_q <= next_addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder: a bit-map/range model checked every
// cycle, plus hand-computed literal expectations.
module tb_imm_encoder;
    import rv_imm_pkg::*;

    localparam int ADDR_W   = 32;
    localparam int ERRCNT_W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [1:0]          in_src = 2'b00;
    logic [31:0]         in_imm = '0;
    logic [31:0]         in_base = '0;
    logic                addr_load = 1'b0;
    logic [ADDR_W-1:0]   addr_start = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [31:0]         out_instr;
    logic [ADDR_W-1:0]   out_addr;
    logic                out_err;
    logic [ERRCNT_W-1:0] err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    imm_encoder #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_src     (in_src),
        .in_imm     (in_imm),
        .in_base    (in_base),
        .addr_load  (addr_load),
        .addr_start (addr_start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Which immediate bit lands at each instruction bit position (-1: keep base bit).
    function automatic int imm_index(input int fmt, input int pos);
        case (fmt)
            0: return (pos >= 20) ? pos - 20 : -1;
            1: begin
                if (pos >= 25) return pos - 20;
                if (pos >= 7 && pos <= 11) return pos - 7;
                return -1;
            end
            2: begin
                if (pos == 31) return 12;
                if (pos >= 25) return pos - 20;
                if (pos >= 8 && pos <= 11) return pos - 7;
                if (pos == 7) return 11;
                return -1;
            end
            default: begin
                if (pos == 31) return 20;
                if (pos >= 21) return pos - 20;
                if (pos == 20) return 11;
                if (pos >= 12) return pos;
                return -1;
            end
        endcase
    endfunction

    function automatic logic [31:0] model_encode(input int fmt, input logic [31:0] imm,
                                                 input logic [31:0] base);
        logic [31:0] r;
        for (int p = 0; p < 32; p++) begin
            int k;
            k = imm_index(fmt, p);
            r[p] = (k >= 0) ? imm[k] : base[p];
        end
        return r;
    endfunction

    function automatic logic model_fits(input int fmt, input logic [31:0] imm);
        longint v;
        v = longint'($signed(imm));
        case (fmt)
            0, 1: return (v >= -2048) && (v <= 2047);
            2:    return (v >= -4096) && (v <= 4095) && !imm[0];
            default: return (v >= -1048576) && (v <= 1048575) && !imm[0];
        endcase
    endfunction

    logic        m_live  = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_addr  = '0;
    logic        m_err   = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_next  = '0;

    // Transaction-level model of the output register, address counter and error count.
    always @(posedge clk) begin
        logic [31:0] b;
        if (rst) begin
            m_live = 1'b1; m_valid = 1'b0; m_instr = '0; m_addr = '0;
            m_err = 1'b0; m_cnt = 0; m_next = '0;
        end else if (m_live) begin
            if (in_valid && (!m_valid || out_ready)) begin
                b       = addr_load ? addr_start : m_next;
                m_valid = 1'b1;
                m_instr = model_encode(int'(in_src), in_imm, in_base);
                m_err   = !model_fits(int'(in_src), in_imm);
                m_addr  = b;
                m_next  = b + 32'd4;
                if (m_err && m_cnt < 255) m_cnt++;
            end else begin
                if (out_ready) m_valid = 1'b0;
                if (addr_load) m_next = addr_start;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("m_out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("m_in_ready",  32'(in_ready),  32'(!m_valid || out_ready));
            checkOutput("m_err_cnt",   32'(err_cnt),   32'(m_cnt));
            checkOutput("m_out_instr", out_instr, m_instr);
            checkOutput("m_out_addr",  out_addr,  m_addr);
            checkOutput("m_out_err",   32'(out_err),   32'(m_err));
        end
    end

    task automatic applyStimulus(input logic v, input logic [1:0] src, input logic [31:0] imm,
                                 input logic [31:0] base, input logic ld,
                                 input logic [31:0] start, input logic ordy);
        in_valid   = v;
        in_src     = src;
        in_imm     = imm;
        in_base    = base;
        addr_load  = ld;
        addr_start = start;
        out_ready  = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 2'b00, '0, '0, 0, '0, 1);
        rst = 1'b0;
    endtask

    logic [31:0] op_imm, op_store, op_branch, op_jal;

    initial begin
        op_imm    = {25'b0, OPC_OP_IMM};
        op_store  = {25'b0, OPC_STORE};
        op_branch = {25'b0, OPC_BRANCH};
        op_jal    = {25'b0, OPC_JAL};

        applyStimulus(0, 2'b00, '0, '0, 0, '0, 1);
        doReset();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_err_cnt",   32'(err_cnt),   32'd0);
        checkOutput("rst_out_addr",  out_addr,       32'd0);
        checkOutput("rst_out_instr", out_instr,      32'd0);

        applyStimulus(1, 2'b00, 32'hFFFFFFFF, 32'h00000093, 0, '0, 1);
        checkOutput("i_instr", out_instr, 32'hFFF00093);
        checkOutput("i_err",   32'(out_err), 32'd0);
        checkOutput("i_addr",  out_addr, 32'h0);

        doReset();
        applyStimulus(1, 2'b01, 32'd8, 32'h0020A023, 0, '0, 1);
        checkOutput("s_instr", out_instr, 32'h0020A423);
        checkOutput("s_addr",  out_addr, 32'h0);
        applyStimulus(1, 2'b10, -32'sd8, op_branch, 0, '0, 1);
        checkOutput("b_instr", out_instr, 32'hFE000CE3);
        checkOutput("b_addr",  out_addr, 32'h4);

        applyStimulus(1, 2'b11, 32'h800, op_jal | 32'h80, 1, 32'h100, 1);
        checkOutput("j_instr", out_instr, 32'h001000EF);
        checkOutput("j_addr",  out_addr, 32'h100);
        applyStimulus(1, 2'b00, 32'd5, op_imm, 0, '0, 1);
        checkOutput("after_load_instr", out_instr, 32'h00500013);
        checkOutput("after_load_addr",  out_addr, 32'h104);

        applyStimulus(1, 2'b00, 32'd2048, 32'h00000093, 0, '0, 1);
        checkOutput("ierr_instr", out_instr, 32'h80000093);
        checkOutput("ierr_err",   32'(out_err), 32'd1);
        checkOutput("ierr_cnt",   32'(err_cnt), 32'd1);
        applyStimulus(1, 2'b10, 32'd3, op_branch, 0, '0, 1);
        checkOutput("berr_instr", out_instr, 32'h00000163);
        checkOutput("berr_err",   32'(out_err), 32'd1);
        checkOutput("berr_cnt",   32'(err_cnt), 32'd2);
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1, 2'b00, 32'd2048, op_imm, 0, '0, 1);
        end
        checkOutput("sat_cnt", 32'(err_cnt), 32'd255);
        applyStimulus(1, 2'b11, 32'hFFF00000, op_jal, 0, '0, 1);
        checkOutput("sat_hold_cnt", 32'(err_cnt), 32'd255);
        checkOutput("j_min_err",    32'(out_err), 32'd0);

        applyStimulus(0, 2'b00, '0, '0, 0, '0, 1);
        checkOutput("drain_valid", 32'(out_valid), 32'd0);

        applyStimulus(1, 2'b00, 32'd1, op_imm, 1, 32'h200, 0);
        checkOutput("bp_a_addr", out_addr, 32'h200);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 2'b00, 32'd2, op_imm, 0, '0, 0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold_addr", out_addr, 32'h200);
            checkOutput("bp_hold_instr", out_instr, 32'h00100013);
        end
        applyStimulus(1, 2'b00, 32'd2, op_imm, 0, '0, 1);
        checkOutput("bp_b_addr",  out_addr, 32'h204);
        checkOutput("bp_b_instr", out_instr, 32'h00200013);
        applyStimulus(1, 2'b00, 32'd3, op_imm, 0, '0, 1);
        checkOutput("bp_c_addr", out_addr, 32'h208);
        applyStimulus(1, 2'b00, 32'd4, op_imm, 0, '0, 1);
        checkOutput("bp_d_addr", out_addr, 32'h20C);

        applyStimulus(1, 2'b00, 32'd0, op_imm, 1, 32'hFFFFFFFC, 1);
        checkOutput("wrap_top_addr", out_addr, 32'hFFFFFFFC);
        applyStimulus(1, 2'b00, 32'd0, op_imm, 0, '0, 1);
        checkOutput("wrap_zero_addr", out_addr, 32'h0);

        applyStimulus(1, 2'b00, 32'd7, op_imm, 0, '0, 0);
        checkOutput("mid_pending", 32'(out_valid), 32'd1);
        rst = 1'b1;
        applyStimulus(1, 2'b00, 32'd8, op_imm, 0, '0, 0);
        rst = 1'b0;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_cnt",   32'(err_cnt),   32'd0);
        applyStimulus(1, 2'b00, 32'd9, op_imm, 0, '0, 1);
        checkOutput("mid_rst_addr",  out_addr, 32'h0);
        checkOutput("mid_rst_instr", out_instr, 32'h00900013);

        applyStimulus(0, 2'b00, '0, '0, 0, '0, 1);
        applyStimulus(0, 2'b00, '0, '0, 0, '0, 1);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the sign extender: takes a 32-bit signed immediate plus an instruction-format selector and scatters it into the RISC-V immediate bit positions of a 32-bit instruction word.
- Range-checks the immediate and tracks the instruction-memory address.
- Sits between the test-program generator / loader and instruction memory.
- Registered valid/ready stream on both sides, one output register stage.

Parameters:
ADDR_W, 32, width of the instruction-memory byte address
ERRCNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_src  input  2  format: 00 I, 01 S, 10 B, 11 J (same code as the sign extender)
in_imm  input  32  signed immediate (byte offset for B/J)
in_base  input  32  instruction with opcode/rd/rs1/rs2/funct fields set; immediate bits ignored
addr_load  input  1  load address counter
addr_start  input  ADDR_W  value loaded on addr_load
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  byte address for out_instr
out_err  output  1  immediate not representable for in_src
err_cnt  output  ERRCNT_W  count of errored beats, saturating

Behaviour:
- Reset (rst=1 at clock edge): out_valid=0, out_instr=0, out_addr=0, out_err=0, err_cnt=0, next-address register=0. in_ready=1 in the cycle after reset.
- Handshakes:
  - in_ready = !out_valid || out_ready (combinational).
  - Input accepted when in_valid && in_ready.
  - Output transferred when out_valid && out_ready.
  - Latency is 1 cycle: an accepted beat appears on the out_* ports the next cycle.
  - Throughput is 1 beat/cycle while out_ready=1.
  - Output holds stable while out_valid && !out_ready.
- Encoding:
  - instr = (in_base & ~mask) | fields.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - mask is the set of bits written for that format.
- Range check (err=1 if violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - An errored beat is still emitted with truncated fields and out_err=1. It consumes an address and is never dropped.
- Address:
  - next_addr register.
  - On accept: out_addr <= next_addr, next_addr <= next_addr+4, wrapping modulo 2^ADDR_W.
  - addr_load sets next_addr <= addr_start.
  - If addr_load and accept occur in the same cycle, the accepted beat uses addr_start and next_addr <= addr_start+4.
  - addr_load never alters a pending out_addr.
- err_cnt increments on accept of an errored beat and saturates at 2^ERRCNT_W-1.
- Reset mid-stream: a pending output is discarded (out_valid=0) and the counters are cleared. An input beat presented in the same cycle as rst is not accepted.

Decomposition:
- Shared package `rv_imm_pkg`:
  - format codes FMT_I/FMT_S/FMT_B/FMT_J (2'b00..2'b11).
  - per-format field masks MASK_I=32'hFFF00000, MASK_S=32'hFE000F80, MASK_B=32'hFE000F80, MASK_J=32'hFFFFF000.
  - opcode constants used by benches.
- One combinational sub-module `imm_scatter` (in_src, in_imm, in_base -> instr, err).
- The top holds the output register, handshake, address counter and error counter.

Test Plan:
- I-type: in_src=00, in_imm=32'hFFFFFFFF, in_base=32'h00000093, out_ready=1 -> next cycle out_instr=32'hFFF00093, out_err=0, out_addr=0.
- S and B: in_src=01, in_imm=8, in_base=32'h0020A023 -> 32'h0020A423. Then in_src=10, in_imm=-8, in_base=32'h00000063 -> 32'hFE000CE3, out_addr=4.
- J plus address load: addr_load=1 with addr_start=32'h100 in the same cycle as in_src=11, in_imm=32'h800, in_base=32'h000000EF -> out_instr=32'h001000EF, out_addr=32'h100. The next beat gets out_addr=32'h104.
- Errors: I with in_imm=2048 -> out_instr=32'h80000093, out_err=1, err_cnt=1. B with in_imm=3 -> out_err=1, err_cnt=2. Further errored beats until err_cnt reaches 255 -> err_cnt holds at 255.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0, no addresses skipped. Release -> back-to-back beats at 1/cycle with consecutive addresses.
- Reset mid-stream: rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, err_cnt=0, and the next accepted beat has out_addr=0.
